// File: rtl/wb_port_arbiter_if.sv
// Bundle of signals between the write-back arbiter and its environment:
// the WB stage, the MDU, the hazard unit and the register-file write port.
interface wb_port_arbiter_if #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            pipe_we;
   logic [4:0]      pipe_rd;
   logic [XLEN-1:0] pipe_wdata;
   logic            mdu_valid;
   logic [4:0]      mdu_rd;
   logic [XLEN-1:0] mdu_wdata;
   logic            mdu_ready;
   logic [4:0]      query_rd;
   logic            query_hit;
   logic            rf_we;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_wdata;
   logic            stall_wb;
   logic [CW-1:0]   fifo_count;

   // Environment side: drives requests and the hazard query, observes results
   modport master (
      output pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata, query_rd,
      input  mdu_ready, query_hit, rf_we, rf_rd, rf_wdata, stall_wb, fifo_count
   );

   // Arbiter side
   modport slave (
      input  pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata, query_rd,
      output mdu_ready, query_hit, rf_we, rf_rd, rf_wdata, stall_wb, fifo_count
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The WB stage normally owns the port;
// MDU results wait in a small FIFO and drain on idle WB cycles. A head
// entry that has waited STARVE_LIMIT cycles forces a one-cycle WB stall
// so it can be written.
module wb_port_arbiter #(
   parameter int XLEN         = 64,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                reset,
   wb_port_arbiter_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } state_t;

   state_t          r_state;
   logic [4:0]      r_mem_rd   [DEPTH];
   logic [XLEN-1:0] r_mem_data [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_age;
   logic            r_rf_we;
   logic [4:0]      r_rf_rd;
   logic [XLEN-1:0] r_rf_wdata;
   logic            r_stall;

   logic            w_full;
   logic            w_empty;
   logic            w_pipe_req;
   logic            w_push;
   logic            w_grant_pipe;
   logic            w_pop;
   state_t          w_state_nxt;
   logic [AW-1:0]   w_age_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic            w_hit;
   logic [PW-1:0]   w_idx;

   assign w_full     = (r_count == CW'(DEPTH));
   assign w_empty    = (r_count == {CW{1'b0}});
   assign w_pipe_req = bus.pipe_we && (bus.pipe_rd != 5'd0);
   // Ready is derived from the registered count only, so a pop cannot
   // open a slot for a push in the same cycle.
   assign w_push     = bus.mdu_valid && !w_full && (bus.mdu_rd != 5'd0);

   // Grant selection and NORMAL/FORCE next-state
   always_comb begin
      w_grant_pipe = 1'b0;
      w_pop        = 1'b0;
      w_state_nxt  = r_state;
      case (r_state)
         ST_NORMAL: begin
            if (w_pipe_req) begin
               w_grant_pipe = 1'b1;
            end else if (!w_empty) begin
               w_pop = 1'b1;
            end else begin
               w_pop = 1'b0;
            end
            if (!w_empty && !w_pop && (r_age == AW'(STARVE_LIMIT - 1))) begin
               w_state_nxt = ST_FORCE;
            end else begin
               w_state_nxt = ST_NORMAL;
            end
         end
         ST_FORCE: begin
            // WB is held this cycle; the head is always present here.
            w_pop       = !w_empty;
            w_state_nxt = ST_NORMAL;
         end
         default: begin
            w_state_nxt = ST_NORMAL;
         end
      endcase
   end

   // Head age and occupancy next values
   always_comb begin
      w_age_nxt   = r_age;
      w_count_nxt = r_count;
      if (w_empty || w_pop) begin
         w_age_nxt = {AW{1'b0}};
      end else begin
         w_age_nxt = r_age + AW'(1);
      end
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Hazard lookup over entries already in the FIFO (head included, incoming push excluded)
   always_comb begin
      w_hit = 1'b0;
      w_idx = r_rptr;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + PW'(k);
         if ((CW'(k) < r_count) && (r_mem_rd[w_idx] == bus.query_rd)) begin
            w_hit = 1'b1;
         end else begin
            w_hit = w_hit;
         end
      end
      if (bus.query_rd == 5'd0) begin
         w_hit = 1'b0;
      end else begin
         w_hit = w_hit;
      end
   end

   // FIFO storage; validity is tracked by the pointers and count, so no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_rd[r_wptr]   <= bus.mdu_rd;
         r_mem_data[r_wptr] <= bus.mdu_wdata;
      end
   end

   // Control state, FIFO pointers and registered write-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_NORMAL;
         r_wptr     <= {PW{1'b0}};
         r_rptr     <= {PW{1'b0}};
         r_count    <= {CW{1'b0}};
         r_age      <= {AW{1'b0}};
         r_rf_we    <= 1'b0;
         r_rf_rd    <= 5'd0;
         r_rf_wdata <= {XLEN{1'b0}};
         r_stall    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_age   <= w_age_nxt;
         r_stall <= (w_state_nxt == ST_FORCE);
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         if (w_grant_pipe) begin
            r_rf_we    <= 1'b1;
            r_rf_rd    <= bus.pipe_rd;
            r_rf_wdata <= bus.pipe_wdata;
         end else if (w_pop) begin
            r_rf_we    <= 1'b1;
            r_rf_rd    <= r_mem_rd[r_rptr];
            r_rf_wdata <= r_mem_data[r_rptr];
         end else begin
            r_rf_we <= 1'b0;
         end
      end
   end

   assign bus.mdu_ready  = !w_full;
   assign bus.query_hit  = w_hit;
   assign bus.rf_we      = r_rf_we;
   assign bus.rf_rd      = r_rf_rd;
   assign bus.rf_wdata   = r_rf_wdata;
   assign bus.stall_wb   = r_stall;
   assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter. Each scenario queues the register
// writes it expects, in order; a negedge monitor checks every rf write
// against that queue. Status outputs are checked inline after edges.
module tb_wb_port_arbiter;
   localparam int XLEN = 64;
   localparam int DEPTH = 4;
   localparam int STARVE = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   wr_t  exp_q[$];
   wr_t  mon_e;

   always #5 clk = ~clk;

   wb_port_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) ifc ();

   wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [63:0] d);
      wr_t w;
      w.rd = rd;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      ifc.pipe_we = 1'b0;
      ifc.pipe_rd = 5'd0;
      ifc.pipe_wdata = 64'd0;
      ifc.mdu_valid = 1'b0;
      ifc.mdu_rd = 5'd0;
      ifc.mdu_wdata = 64'd0;
      ifc.query_rd = 5'd0;
   endtask

   // Scoreboard monitor: every register-file write must match the next expectation
   always @(negedge clk) begin
      if (ifc.rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write",
                     ifc.rf_rd, ifc.rf_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_rd", 64'(ifc.rf_rd), 64'(mon_e.rd));
            chk("wr_data", ifc.rf_wdata, mon_e.data);
         end
      end
   end

   initial begin
      logic        s;
      logic        r;
      logic [63:0] d;
      int          cur;

      idle();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_rf_we", 64'(ifc.rf_we), 64'd0);
      chk("rst_rf_rd", 64'(ifc.rf_rd), 64'd0);
      chk("rst_rf_wdata", ifc.rf_wdata, 64'd0);
      chk("rst_stall", 64'(ifc.stall_wb), 64'd0);
      chk("rst_count", 64'(ifc.fifo_count), 64'd0);
      chk("rst_ready", 64'(ifc.mdu_ready), 64'd1);
      reset = 1'b0;
      tick();

      // Idle-pipe drain: push at t, written at t+2
      expect_wr(5'd5, 64'hAAAA);
      ifc.mdu_valid = 1'b1;
      ifc.mdu_rd = 5'd5;
      ifc.mdu_wdata = 64'hAAAA;
      tick();
      ifc.mdu_valid = 1'b0;
      chk("drain_count1", 64'(ifc.fifo_count), 64'd1);
      tick();
      chk("drain_count0", 64'(ifc.fifo_count), 64'd0);
      tick();
      tick();

      // query_hit behaviour
      expect_wr(5'd2, 64'h22);
      expect_wr(5'd9, 64'h99);
      ifc.pipe_we = 1'b1;
      ifc.pipe_rd = 5'd2;
      ifc.pipe_wdata = 64'h22;
      ifc.mdu_valid = 1'b1;
      ifc.mdu_rd = 5'd9;
      ifc.mdu_wdata = 64'h99;
      ifc.query_rd = 5'd9;
      #1;
      chk("qhit_pushing", 64'(ifc.query_hit), 64'd0);
      tick();
      ifc.pipe_we = 1'b0;
      ifc.mdu_valid = 1'b0;
      chk("qhit_queued", 64'(ifc.query_hit), 64'd1);
      ifc.query_rd = 5'd0;
      #1;
      chk("qhit_x0", 64'(ifc.query_hit), 64'd0);
      ifc.query_rd = 5'd9;
      tick();
      chk("qhit_written", 64'(ifc.query_hit), 64'd0);
      tick();
      tick();

      // Pipe priority and starvation guard
      for (int k = 0; k < 5; k++) expect_wr(5'd1, 64'h100 + 64'(k));
      expect_wr(5'd7, 64'h777);
      expect_wr(5'd1, 64'h105);
      d = 64'h100;
      ifc.pipe_we = 1'b1;
      ifc.pipe_rd = 5'd1;
      ifc.mdu_rd = 5'd7;
      ifc.mdu_wdata = 64'h777;
      for (int c = 0; c < 7; c++) begin
         ifc.pipe_wdata = d;
         ifc.mdu_valid = (c == 0);
         s = ifc.stall_wb;
         chk($sformatf("starve_stall_c%0d", c), 64'(s), (c == 5) ? 64'd1 : 64'd0);
         tick();
         if (!s) d = d + 64'd1;
      end
      idle();
      tick();
      tick();

      // Full FIFO with busy pipe
      for (int k = 0; k < 5; k++) expect_wr(5'd3, 64'h300 + 64'(k));
      expect_wr(5'd8, 64'h1008);
      expect_wr(5'd3, 64'h305);
      for (int k = 9; k <= 12; k++) expect_wr(5'(k), 64'h1000 + 64'(k));
      d = 64'h300;
      cur = 8;
      ifc.pipe_we = 1'b1;
      ifc.pipe_rd = 5'd3;
      for (int c = 0; c < 7; c++) begin
         ifc.pipe_wdata = d;
         ifc.mdu_valid = (cur <= 12);
         ifc.mdu_rd = 5'(cur);
         ifc.mdu_wdata = 64'h1000 + 64'(cur);
         s = ifc.stall_wb;
         r = ifc.mdu_ready;
         if (c == 4) begin
            chk("full_ready_c4", 64'(r), 64'd0);
            chk("full_count_c4", 64'(ifc.fifo_count), 64'd4);
         end
         if (c == 5) begin
            chk("full_ready_c5", 64'(r), 64'd0);
            chk("full_stall_c5", 64'(s), 64'd1);
         end
         if (c == 6) chk("full_ready_c6", 64'(r), 64'd1);
         tick();
         if (!s) d = d + 64'd1;
         if (r && ifc.mdu_valid) cur++;
      end
      chk("full_all_accepted", 64'(cur), 64'd13);
      idle();
      for (int c = 0; c < 6; c++) tick();
      chk("full_drained", 64'(ifc.fifo_count), 64'd0);

      // x0 filtering on both sources
      expect_wr(5'd4, 64'h44);
      ifc.pipe_we = 1'b1;
      ifc.pipe_rd = 5'd0;
      ifc.pipe_wdata = 64'hDEAD;
      ifc.mdu_valid = 1'b1;
      ifc.mdu_rd = 5'd4;
      ifc.mdu_wdata = 64'h44;
      tick();
      chk("x0_count1", 64'(ifc.fifo_count), 64'd1);
      ifc.mdu_rd = 5'd0;
      ifc.mdu_wdata = 64'h55;
      chk("x0_ready", 64'(ifc.mdu_ready), 64'd1);
      tick();
      chk("x0_count0", 64'(ifc.fifo_count), 64'd0);
      idle();
      tick();
      tick();

      // Reset mid-traffic discards the queued entries
      for (int k = 0; k < 3; k++) expect_wr(5'd6, 64'h600 + 64'(k));
      ifc.pipe_we = 1'b1;
      ifc.pipe_rd = 5'd6;
      for (int c = 0; c < 3; c++) begin
         ifc.pipe_wdata = 64'h600 + 64'(c);
         ifc.mdu_valid = 1'b1;
         ifc.mdu_rd = 5'(20 + c);
         ifc.mdu_wdata = 64'h2000 + 64'(c);
         tick();
      end
      chk("rstm_count3", 64'(ifc.fifo_count), 64'd3);
      ifc.mdu_valid = 1'b0;
      ifc.pipe_wdata = 64'h603;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      ifc.query_rd = 5'd20;
      #1;
      chk("rstm_rf_we", 64'(ifc.rf_we), 64'd0);
      chk("rstm_count", 64'(ifc.fifo_count), 64'd0);
      chk("rstm_ready", 64'(ifc.mdu_ready), 64'd1);
      chk("rstm_stall", 64'(ifc.stall_wb), 64'd0);
      chk("rstm_qhit", 64'(ifc.query_hit), 64'd0);
      for (int c = 0; c < 8; c++) tick();

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Shares that port between the in-order pipeline write-back stage and a long-latency unit (MDU: mul/div).
- MDU results are queued in a small FIFO. Pipeline write-back has priority, with a starvation guard that stalls write-back to drain the FIFO.
- Sits between the WB stage and the register file. Its stall output feeds the WB stage stall input.

Parameters:
- XLEN, 64, data width.
- DEPTH, 4, MDU result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before a forced drain (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- pipe_we  in  1  WB-stage write request.
- pipe_rd  in  5  WB-stage destination register.
- pipe_wdata  in  XLEN  WB-stage data.
- mdu_valid  in  1  MDU result valid.
- mdu_rd  in  5  MDU destination register.
- mdu_wdata  in  XLEN  MDU data.
- mdu_ready  out  1  FIFO can accept; equals !full.
- query_rd  in  5  hazard-unit lookup register.
- query_hit  out  1  combinational; 1 if query_rd!=0 and a valid FIFO entry targets query_rd.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file address (registered).
- rf_wdata  out  XLEN  register-file data (registered).
- stall_wb  out  1  registered; holds the WB stage.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Single clock clk. Reset is synchronous and active-high on reset.
- Reset values:
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - stall_wb=0, fifo_count=0, mdu_ready=1.
  - FIFO pointers=0, age counter=0, state=NORMAL.
- Reset mid-operation discards all queued MDU results.
- Requests to x0:
  - pipe request exists only if pipe_we=1 and pipe_rd!=0.
  - MDU handshake with mdu_rd=0 completes (accepted) but is not enqueued.
- Enqueue:
  - Occurs when mdu_valid && mdu_ready && mdu_rd!=0.
  - mdu_ready depends only on the registered count, so when full no enqueue occurs even if a pop happens the same cycle.
  - Simultaneous push and pop are legal when not full; count unchanged.
- Pointers wrap modulo DEPTH.
- States: NORMAL, FORCE.
- NORMAL grant rule, evaluated each cycle:
  - If a pipe request exists: grant pipe.
  - Else if FIFO is non-empty: grant FIFO head and pop.
  - Else: no write.
- Age counter:
  - Increments when FIFO is non-empty and the head is not popped.
  - Clears on pop or when FIFO is empty.
- NORMAL to FORCE transition:
  - Occurs when age==STARVE_LIMIT-1 and the head is not popped this cycle.
  - stall_wb becomes 1 in the next cycle.
- FORCE state:
  - stall_wb=1 for exactly one cycle.
  - Pipe request is ignored; the WB stage is held and re-presents next cycle.
  - FIFO head is granted and popped, age clears, then return to NORMAL.
  - FIFO is guaranteed non-empty in FORCE.
- Latency: the granted write appears on rf_we/rf_rd/rf_wdata one cycle after the grant. Cycles with no grant drive rf_we=0 and hold rf_rd/rf_wdata.
- An MDU result reaches rf_we no earlier than the cycle after its push; there is no bypass.
- Ordering: same-rd ordering between the pipe and the FIFO is not resolved here. The hazard unit uses query_hit to hold dependent instructions.
- query_hit:
  - Covers only entries that are currently valid.
  - Excludes an entry being pushed this cycle.
  - Includes an entry being popped this cycle.

Test Plan:
- Reset mid-traffic: load 3 entries, assert reset for 1 cycle -> rf_we=0, fifo_count=0, mdu_ready=1, stall_wb=0; no further MDU writes appear.
- Idle-pipe drain: pipe_we=0, push {rd=5, 0xAAAA} at cycle t -> rf_we=1, rf_rd=5, rf_wdata=0xAAAA at t+2; fifo_count returns to 0.
- Pipe priority and starvation (STARVE_LIMIT=4): continuous pipe writes to rd=1, one MDU entry rd=7 -> 4 pipe grants, then stall_wb=1 for one cycle with rf_rd=7 written; the held pipe write to rd=1 lands the following cycle, none lost.
- Full FIFO (DEPTH=4): pipe busy, mdu_valid held high with rd=8..11 then 12 -> mdu_ready=0 after 4 pushes, rd=12 not accepted until the first pop; all five drain in order 8,9,10,11,12.
- x0 filtering: pipe_we=1 with pipe_rd=0 alongside a queued entry -> FIFO head granted, no rf write to x0. MDU push with rd=0 -> accepted, fifo_count unchanged.
- query_hit: entry rd=9 queued, query_rd=9 -> 1. query_rd=0 -> 0. After rd=9 is written, query_rd=9 -> 0.
